// File: rtl/mul_iter_unit.sv
// Iterative shift-add multiplier for MUL/UMULL/SMULL. It processes one multiplier bit per clock
// through a single shared adder and returns a 2*WIDTH-bit product with {N,Z} flags.
module mul_iter_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic             Signed,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] ResultLo,
    output logic [WIDTH-1:0] ResultHi,
    output logic [1:0]       MulFlags
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Unsigned magnitude of a two's-complement word; the most-negative value maps to 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
        magnitude = x[WIDTH-1] ? (~x + {{(WIDTH-1){1'b0}}, 1'b1}) : x;
    endfunction

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic [2*WIDTH-1:0] res_q, res_d;
    logic [1:0]         flags_q, flags_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   addend_s;
    logic [WIDTH:0]     sum_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] final_s;

    // One bit-step: conditional add into the upper half, then shift {carry,acc,multiplier} right.
    always_comb begin
        addend_s = mplier_q[0] ? mcand_q : '0;
        sum_s    = {1'b0, acc_q} + {1'b0, addend_s};
        prod_s   = {sum_s[WIDTH:1], sum_s[0], mplier_q[WIDTH-1:1]};
        if (neg_q) begin
            final_s = ~prod_s + {{(2*WIDTH-1){1'b0}}, 1'b1};
        end else begin
            final_s = prod_s;
        end
    end

    // Next-state and next-datapath logic.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        res_d    = res_q;
        flags_d  = flags_q;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    mcand_d  = Signed ? magnitude(SrcA) : SrcA;
                    mplier_d = Signed ? magnitude(SrcB) : SrcB;
                    neg_d    = Signed & (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_RUN: begin
                acc_d    = prod_s[2*WIDTH-1:WIDTH];
                mplier_d = prod_s[WIDTH-1:0];
                cnt_d    = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                if (cnt_q == LAST_CNT) begin
                    res_d   = final_s;
                    flags_d = {final_s[2*WIDTH-1], (final_s == '0)};
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers; the result and flags only move on the DONE-entry edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            res_q    <= '0;
            flags_q  <= 2'b01;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            res_q    <= res_d;
            flags_q  <= flags_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign Busy     = busy_q;
    assign Done     = done_q;
    assign ResultLo = res_q[WIDTH-1:0];
    assign ResultHi = res_q[2*WIDTH-1:WIDTH];
    assign MulFlags = flags_q;

endmodule

// File: tb/tb_mul_iter_unit.sv
// Bench for mul_iter_unit: a cycle-timeline model built on plain 64-bit multiplication is compared
// every cycle, and directed operations carry hand-computed literal expectations.
module tb_mul_iter_unit;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          Start = 1'b0;
    logic          Signed = 1'b0;
    logic [W-1:0]  SrcA = '0;
    logic [W-1:0]  SrcB = '0;
    logic          Busy;
    logic          Done;
    logic [W-1:0]  ResultLo;
    logic [W-1:0]  ResultHi;
    logic [1:0]    MulFlags;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    mul_iter_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .Start(Start), .Signed(Signed),
        .SrcA(SrcA), .SrcB(SrcB), .Busy(Busy), .Done(Done),
        .ResultLo(ResultLo), .ResultHi(ResultHi), .MulFlags(MulFlags)
    );

    always #5 clk = ~clk;

    // Reference: {N,Z,product} by plain arithmetic.
    function automatic logic [65:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic signed [63:0] sa, sb;
        logic [63:0] p;
        if (s) begin
            sa = $signed(a);
            sb = $signed(b);
            p = sa * sb;
        end else begin
            p = {32'd0, a} * {32'd0, b};
        end
        return {p[63], (p == 64'd0), p};
    endfunction

    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [63:0] m_res = 64'd0;
    logic [1:0]  m_flags = 2'b01;
    logic [65:0] m_pend = 66'd0;
    int          m_cnt = 0;

    // Timeline model: idle -> WIDTH busy cycles -> one done cycle.
    always @(posedge clk) begin
        if (reset) begin
            m_busy = 1'b0; m_done = 1'b0; m_res = 64'd0; m_flags = 2'b01; m_cnt = 0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_busy) begin
            m_cnt++;
            if (m_cnt == W) begin
                m_busy = 1'b0; m_done = 1'b1;
                m_flags = m_pend[65:64]; m_res = m_pend[63:0];
            end
        end else if (Start) begin
            m_busy = 1'b1; m_cnt = 0;
            m_pend = ref_mul(SrcA, SrcB, Signed);
        end
    end

    // Per-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            total++;
            if ({Busy, Done, MulFlags, ResultHi, ResultLo} !== {m_busy, m_done, m_flags, m_res}) begin
                bad++;
                $display("FAIL cycle_model t=%0t: got busy=%b done=%b f=%b hi=%h lo=%h, want busy=%b done=%b f=%b res=%h",
                         $time, Busy, Done, MulFlags, ResultHi, ResultLo, m_busy, m_done, m_flags, m_res);
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input int inj_at, input int rst_at,
                         input logic [31:0] eh, input logic [31:0] el, input logic [1:0] ef,
                         input string nm);
        int lat;
        bit seen;
        lat = 0;
        seen = 1'b0;
        @(negedge clk);
        SrcA = a; SrcB = b; Signed = s; Start = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) begin
                Start = 1'b0; SrcA = $urandom; SrcB = $urandom; Signed = ~s;
            end
            if (inj_at != 0 && k == inj_at) Start = 1'b1;
            if (inj_at != 0 && k == inj_at + 1) Start = 1'b0;
            if (rst_at != 0 && k == rst_at) reset = 1'b1;
            if (rst_at != 0 && k == rst_at + 1) begin
                reset = 1'b0;
                chk({nm, "_busy_after_reset"}, {63'd0, Busy}, 64'd0);
                chk({nm, "_res_after_reset"}, {ResultHi, ResultLo}, 64'd0);
                chk({nm, "_flags_after_reset"}, {62'd0, MulFlags}, 64'd1);
            end
            if (Done) begin
                seen = 1'b1; lat = k;
                break;
            end
        end
        if (rst_at != 0) begin
            chk({nm, "_no_done"}, {63'd0, seen}, 64'd0);
        end else begin
            chk({nm, "_latency"}, 64'(lat), 64'(W + 1));
            chk({nm, "_hi"}, {32'd0, ResultHi}, {32'd0, eh});
            chk({nm, "_lo"}, {32'd0, ResultLo}, {32'd0, el});
            chk({nm, "_flags"}, {62'd0, MulFlags}, {62'd0, ef});
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_state", {Busy, Done, MulFlags, ResultHi, ResultLo}, {1'b0, 1'b0, 2'b01, 64'd0});
        chk_en = 1'b1;
        reset = 1'b0;
        do_op(32'd3, 32'd5, 1'b0, 0, 0, 32'h0000_0000, 32'h0000_000F, 2'b00, "u_3x5");
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 0, 32'hFFFF_FFFE, 32'h0000_0001, 2'b10, "u_max");
        do_op(32'hFFFF_FFFE, 32'h0000_0003, 1'b1, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 2'b10, "s_m2x3");
        do_op(32'h8000_0000, 32'h8000_0000, 1'b1, 0, 0, 32'h4000_0000, 32'h0000_0000, 2'b00, "s_minsq");
        do_op(32'h0000_0000, 32'h8000_0000, 1'b1, 0, 0, 32'h0000_0000, 32'h0000_0000, 2'b01, "s_zero");
        do_op(32'd7, 32'd9, 1'b0, 10, 0, 32'h0000_0000, 32'h0000_003F, 2'b00, "start_ignored");
        do_op(32'h0000_1234, 32'h0000_0010, 1'b0, 0, 12, 32'h0, 32'h0, 2'b00, "mid_reset");
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0, 0, 32'h0000_0000, 32'h0000_0001, 2'b00, "s_m1xm1");
        do_op(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 0, 0, 32'hC000_0000, 32'h8000_0000, 2'b10, "s_maxxmin");
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
